multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALUCTL_W, default 5, ALUControl width (min 5; codes zero-extended).
REQ-002 SHALL have parameter MULT_CYCLES, default 4, extra execute cycles for mult (legal 1..16).
REQ-003 SHALL have ports:
  - Clk  in  1  sole clock, rising edge.
  - Reset  in  1  asynchronous, active-high.
  - Instruction  in  32  current instruction word, stable from DECODE onward.
  - BranchTaken  in  1  ALU branch-condition result, valid in EXEC.
  - IRWrite  out  1  latch Instruction.
  - PCWrite  out  1  PC update.
  - RegWrite  out  1  register file write.
  - ALUSrc  out  1  select immediate.
  - RegDst  out  1  select rd.
  - MemWrite  out  1  data memory write.
  - MemRead  out  1  data memory read.
  - MemToReg  out  1  1 = ALU result, 0 = memory data.
  - Branch  out  1  PC source = branch target.
  - Jump  out  1  PC source = jump target.
  - Jr  out  1  PC source = rs.
  - Jal  out  1  write PC+4 to $31.
  - ALUControl  out  ALUCTL_W  ALU operation code.
  - Busy  out  1  high in every state except FETCH.
  - Illegal  out  1  one-cycle pulse on an undecodable instruction.

Function
REQ-004 SHALL be a registered Moore FSM with states FETCH, DECODE, EXEC, MULT_WAIT, MEM, WB; all outputs are functions of the state and a decode register loaded in DECODE.
REQ-005 FETCH SHALL assert IRWrite and PCWrite (PC+4) for one cycle, then go to DECODE.
REQ-006 DECODE SHALL register the opcode and funct decode.
  - Instruction 32'h0 (nop) returns to FETCH.
  - Illegal opcode or funct pulses Illegal and returns to FETCH with no writes.
  - Everything else goes to EXEC.
REQ-007 ALU codes SHALL be: add 1, sub 2, mult 3, sll 4, srl 5, and 6, or 7, xor 8, beq 12, nor 13, slt 14, bne/bgez 15, bgtz 16, blez 17. I-type ops use the same codes as their R-type counterparts; load/store address uses add.
REQ-008 sll SHALL be decoded by funct 000000 only when Instruction != 0. jr SHALL be R-type funct 001000.
REQ-009 R-type and I-type ALU ops SHALL take EXEC->WB, 4 cycles total. WB asserts RegWrite and MemToReg=1; RegDst=1 for R-type, 0 for I-type.
REQ-010 lw/lh/lb SHALL take EXEC->MEM->WB, 5 cycles: MemRead in MEM, RegWrite with MemToReg=0 in WB.
REQ-011 sw/sh/sb SHALL take EXEC->MEM, 4 cycles: MemWrite for exactly one cycle in MEM.
REQ-012 beq/bne/branch ops SHALL complete in EXEC, 3 cycles: Branch=1, PCWrite=BranchTaken.
REQ-013 j/jal/jr SHALL complete in EXEC, 3 cycles: PCWrite=1, with Jump, Jump+Jal+RegWrite, or Jr respectively.
REQ-014 mult SHALL hold EXEC then MULT_WAIT for MULT_CYCLES cycles, counted down by a counter wide enough for 16, then go to WB: 4+MULT_CYCLES cycles total.
REQ-015 Outside the cycles listed above, all write/read strobes SHALL be 0; no output is ever X.

Reset
REQ-016 Reset SHALL force state FETCH-pending, clear the decode register and counter, and drive every output to 0 (Busy=0, ALUControl=0), immediately and asynchronously, including mid-instruction.
REQ-017 The first rising edge after Reset deasserts SHALL enter FETCH; an aborted instruction produces no further writes.

Configuration
REQ-018 With macro REGIMM_BRANCH_EN defined, the following SHALL be decoded:
  - bgez (op 000001, rt 00001) and bltz (op 000001, rt 00000), codes 15/12.
  - bgtz (000111), code 16.
  - blez (000110), code 17.
  These behave per REQ-012.
REQ-019 Without REGIMM_BRANCH_EN, those opcodes SHALL be Illegal.

Structure
REQ-020 Package mips_ctrl_pkg SHALL hold the opcode/funct constants, ALU code constants and the state enumeration.
REQ-021 A combinational sub-module alu_decoder (opcode, funct, rt -> ALUControl, illegal) SHALL be instantiated once.

Verification
REQ-022 0x00221820 (add) after reset -> IRWrite at cycle 1, RegWrite+RegDst at cycle 4, ALUControl=1, Busy low at cycle 5.
REQ-023 0x8C220004 (lw) -> MemRead at cycle 4 only, RegWrite with MemToReg=0 at cycle 5.
REQ-024 0x10220002 (beq):
  - BranchTaken=1 -> PCWrite+Branch at cycle 3.
  - BranchTaken=0 -> no PCWrite at cycle 3.
REQ-025 0x00220018 (mult), MULT_CYCLES=4 -> ALUControl=3, WB RegWrite at cycle 8; Reset pulsed at cycle 5 -> all outputs 0, no RegWrite afterwards.
REQ-026 0x04210003 (bgez):
  - Macro defined -> ALUControl=15, Branch at cycle 3.
  - Macro undefined -> Illegal pulse at cycle 2, next FETCH at cycle 3.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared opcode/funct encodings, ALU operation codes, FSM state encodings and
// the decode-register layout for the multicycle MIPS controller.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_MULT = 5'd3;
    localparam logic [4:0] ALU_SLL  = 5'd4;
    localparam logic [4:0] ALU_SRL  = 5'd5;
    localparam logic [4:0] ALU_AND  = 5'd6;
    localparam logic [4:0] ALU_OR   = 5'd7;
    localparam logic [4:0] ALU_XOR  = 5'd8;
    localparam logic [4:0] ALU_BEQ  = 5'd12;
    localparam logic [4:0] ALU_NOR  = 5'd13;
    localparam logic [4:0] ALU_SLT  = 5'd14;
    localparam logic [4:0] ALU_BNE  = 5'd15;
    localparam logic [4:0] ALU_BGTZ = 5'd16;
    localparam logic [4:0] ALU_BLEZ = 5'd17;

    // S_PEND is the reset holding state: all outputs low until the first edge.
    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXEC      = 3'd2;
    localparam logic [2:0] S_MULT_WAIT = 3'd3;
    localparam logic [2:0] S_MEM       = 3'd4;
    localparam logic [2:0] S_WB        = 3'd5;
    localparam logic [2:0] S_PEND      = 3'd6;

    typedef enum logic [3:0] {
        C_NONE, C_RALU, C_IALU, C_LOAD, C_STORE,
        C_BRANCH, C_JUMP, C_JAL, C_JR, C_MULT
    } op_class_e;

    typedef struct packed {
        op_class_e  cls;
        logic [4:0] alu;
    } dec_t;

    function automatic op_class_e op_class(input logic [5:0] op, input logic [5:0] fn);
        op_class_e c;
        c = C_NONE;
        case (op)
            OP_RTYPE: begin
                if (fn == F_JR)        c = C_JR;
                else if (fn == F_MULT) c = C_MULT;
                else                   c = C_RALU;
            end
            OP_J:   c = C_JUMP;
            OP_JAL: c = C_JAL;
            OP_BEQ, OP_BNE, OP_REGIMM, OP_BLEZ, OP_BGTZ: c = C_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: c = C_IALU;
            OP_LB, OP_LH, OP_LW: c = C_LOAD;
            OP_SB, OP_SH, OP_SW: c = C_STORE;
            default: c = C_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle; master is the controller, slave the datapath.
// Signal names follow the datapath's established control-line names.
interface multicycle_controller_if #(
    parameter int ALUCTL_W = 5
);
    logic [31:0]         Instruction;
    logic                BranchTaken;
    logic                IRWrite;
    logic                PCWrite;
    logic                RegWrite;
    logic                ALUSrc;
    logic                RegDst;
    logic                MemWrite;
    logic                MemRead;
    logic                MemToReg;
    logic                Branch;
    logic                Jump;
    logic                Jr;
    logic                Jal;
    logic [ALUCTL_W-1:0] ALUControl;
    logic                Busy;
    logic                Illegal;

    modport master (
        input  Instruction, BranchTaken,
        output IRWrite, PCWrite, RegWrite, ALUSrc, RegDst, MemWrite, MemRead,
               MemToReg, Branch, Jump, Jr, Jal, ALUControl, Busy, Illegal
    );

    modport slave (
        output Instruction, BranchTaken,
        input  IRWrite, PCWrite, RegWrite, ALUSrc, RegDst, MemWrite, MemRead,
               MemToReg, Branch, Jump, Jr, Jal, ALUControl, Busy, Illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational opcode/funct/rt -> ALU code and illegal flag.
// REGIMM_BRANCH_EN adds bgez/bltz/bgtz/blez; without it those opcodes are illegal.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rt,
    output logic [4:0] o_alu_ctl,
    output logic       o_illegal
);
`ifndef REGIMM_BRANCH_EN
    logic w_unused_rt;
    assign w_unused_rt = ^i_rt;
`endif

    always_comb begin
        o_alu_ctl = ALU_NONE;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    F_ADD, F_ADDU: o_alu_ctl = ALU_ADD;
                    F_SUB, F_SUBU: o_alu_ctl = ALU_SUB;
                    F_MULT:        o_alu_ctl = ALU_MULT;
                    F_SLL:         o_alu_ctl = ALU_SLL;
                    F_SRL:         o_alu_ctl = ALU_SRL;
                    F_AND:         o_alu_ctl = ALU_AND;
                    F_OR:          o_alu_ctl = ALU_OR;
                    F_XOR:         o_alu_ctl = ALU_XOR;
                    F_NOR:         o_alu_ctl = ALU_NOR;
                    F_SLT:         o_alu_ctl = ALU_SLT;
                    F_JR:          o_alu_ctl = ALU_NONE;
                    default:       o_illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: o_alu_ctl = ALU_ADD;
            OP_SLTI:           o_alu_ctl = ALU_SLT;
            OP_ANDI:           o_alu_ctl = ALU_AND;
            OP_ORI:            o_alu_ctl = ALU_OR;
            OP_XORI:           o_alu_ctl = ALU_XOR;
            OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: o_alu_ctl = ALU_ADD;
            OP_BEQ:            o_alu_ctl = ALU_BEQ;
            OP_BNE:            o_alu_ctl = ALU_BNE;
            OP_J, OP_JAL:      o_alu_ctl = ALU_NONE;
`ifdef REGIMM_BRANCH_EN
            OP_REGIMM: begin
                case (i_rt)
                    RT_BGEZ: o_alu_ctl = ALU_BNE;
                    RT_BLTZ: o_alu_ctl = ALU_BEQ;
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_BGTZ:           o_alu_ctl = ALU_BGTZ;
            OP_BLEZ:           o_alu_ctl = ALU_BLEZ;
`endif
            default:           o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Moore multicycle MIPS control FSM: 3 cycles (branch/jump), 4 (ALU/store), 5 (load),
// 4+MULT_CYCLES (mult). REGIMM_BRANCH_EN enables the REGIMM/bgtz/blez branches.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTL_W    = 5,
    parameter int MULT_CYCLES = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    multicycle_controller_if.master bus
);
    logic [2:0] r_state;
    logic [2:0] w_next;
    dec_t       r_dec;
    logic [4:0] r_cnt;

    logic [4:0] w_alu;
    logic       w_dec_illegal;
    logic       w_nop;
    op_class_e  w_cls;

    alu_decoder u_alu_decoder (
        .i_opcode  (bus.Instruction[31:26]),
        .i_funct   (bus.Instruction[5:0]),
        .i_rt      (bus.Instruction[20:16]),
        .o_alu_ctl (w_alu),
        .o_illegal (w_dec_illegal)
    );

    // An all-zero word would otherwise decode as sll; it is a nop.
    assign w_nop = (bus.Instruction == 32'h0);
    assign w_cls = op_class(bus.Instruction[31:26], bus.Instruction[5:0]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_PEND:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = (w_nop || w_dec_illegal) ? S_FETCH : S_EXEC;
            S_EXEC: begin
                case (r_dec.cls)
                    C_RALU, C_IALU:  w_next = S_WB;
                    C_LOAD, C_STORE: w_next = S_MEM;
                    C_MULT:          w_next = S_MULT_WAIT;
                    default:         w_next = S_FETCH;
                endcase
            end
            S_MULT_WAIT: w_next = (r_cnt <= 5'd1) ? S_WB : S_MULT_WAIT;
            S_MEM:       w_next = (r_dec.cls == C_LOAD) ? S_WB : S_FETCH;
            S_WB:        w_next = S_FETCH;
            default:     w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_PEND;
            r_dec   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_dec <= '{cls: w_cls, alu: w_alu};
            end
            if (r_state == S_EXEC) begin
                r_cnt <= 5'(MULT_CYCLES);
            end else if (r_state == S_MULT_WAIT && r_cnt != 5'd0) begin
                r_cnt <= r_cnt - 5'd1;
            end
        end
    end

    logic w_fetch, w_decode, w_exec, w_mem, w_wb, w_active;
    assign w_fetch  = (r_state == S_FETCH);
    assign w_decode = (r_state == S_DECODE);
    assign w_exec   = (r_state == S_EXEC);
    assign w_mem    = (r_state == S_MEM);
    assign w_wb     = (r_state == S_WB);
    assign w_active = w_exec || w_mem || w_wb || (r_state == S_MULT_WAIT);

    assign bus.IRWrite  = w_fetch;
    assign bus.PCWrite  = w_fetch
                        || (w_exec && r_dec.cls == C_BRANCH && bus.BranchTaken)
                        || (w_exec && (r_dec.cls == C_JUMP || r_dec.cls == C_JAL || r_dec.cls == C_JR));
    assign bus.RegWrite = w_wb || (w_exec && r_dec.cls == C_JAL);
    assign bus.ALUSrc   = w_active
                        && (r_dec.cls == C_IALU || r_dec.cls == C_LOAD || r_dec.cls == C_STORE);
    assign bus.RegDst   = w_wb && (r_dec.cls == C_RALU || r_dec.cls == C_MULT);
    assign bus.MemWrite = w_mem && r_dec.cls == C_STORE;
    assign bus.MemRead  = w_mem && r_dec.cls == C_LOAD;
    assign bus.MemToReg = w_wb && r_dec.cls != C_LOAD;
    assign bus.Branch   = w_exec && r_dec.cls == C_BRANCH;
    assign bus.Jump     = w_exec && (r_dec.cls == C_JUMP || r_dec.cls == C_JAL);
    assign bus.Jr       = w_exec && r_dec.cls == C_JR;
    assign bus.Jal      = w_exec && r_dec.cls == C_JAL;
    assign bus.ALUControl = w_active ? ALUCTL_W'(r_dec.alu) : '0;
    assign bus.Busy     = !(w_fetch || r_state == S_PEND);
    assign bus.Illegal  = w_decode && !w_nop && w_dec_illegal;
endmodule
